riscv_alu_arbiter: RTL



---
 rtl/riscv_alu_arbiter_pkg.sv | 4 +
 rtl/riscv_constants.sv | 23 ++
 rtl/riscv_alu.sv | 38 +++
 rtl/riscv_rr_arbiter.sv | 35 +++
 rtl/riscv_alu_arbiter.sv | 70 +++++++
 5 files changed

// File: rtl/riscv_alu_arbiter_pkg.sv
// riscv_alu_arbiter_pkg: response-register state type for the shared-ALU arbiter.
package riscv_alu_arbiter_pkg;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} resp_state_e;
endpackage

// File: rtl/riscv_constants.sv
// riscv_constants: execute-stage function codes shared by the ALU and its clients.
package riscv_constants;
    localparam int EXEC_FUN_W = 5;
    typedef enum logic [EXEC_FUN_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_JALR = 5'd10,
        ALU_BEQ  = 5'd11,
        ALU_BNE  = 5'd12,
        ALU_BLT  = 5'd13,
        ALU_BGE  = 5'd14,
        ALU_BLTU = 5'd15,
        ALU_BGEU = 5'd16
    } exec_fun_e;
endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational integer ALU and branch comparator; unknown codes give 0/0.
module riscv_alu
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [EXEC_FUN_W-1:0]  fun,
    input  logic [WORD_LENGTH-1:0] a,
    input  logic [WORD_LENGTH-1:0] b,
    output logic [WORD_LENGTH-1:0] alu_out,
    output logic                   br_flag
);
    localparam int SH = $clog2(WORD_LENGTH);
    always_comb begin
        alu_out = '0;
        br_flag = 1'b0;
        case (fun)
            ALU_ADD:  alu_out = a + b;
            ALU_SUB:  alu_out = a - b;
            ALU_SLL:  alu_out = a << b[SH-1:0];
            ALU_SLT:  alu_out = {{(WORD_LENGTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_out = {{(WORD_LENGTH-1){1'b0}}, a < b};
            ALU_XOR:  alu_out = a ^ b;
            ALU_SRL:  alu_out = a >> b[SH-1:0];
            ALU_SRA:  alu_out = $signed(a) >>> b[SH-1:0];
            ALU_OR:   alu_out = a | b;
            ALU_AND:  alu_out = a & b;
            ALU_JALR: alu_out = (a + b) & {{(WORD_LENGTH-1){1'b1}}, 1'b0};
            ALU_BEQ:  br_flag = a == b;
            ALU_BNE:  br_flag = a != b;
            ALU_BLT:  br_flag = $signed(a) < $signed(b);
            ALU_BGE:  br_flag = $signed(a) >= $signed(b);
            ALU_BLTU: br_flag = a < b;
            ALU_BGEU: br_flag = a >= b;
            default:  alu_out = '0;
        endcase
    end
endmodule

// File: rtl/riscv_rr_arbiter.sv
// riscv_rr_arbiter: round-robin one-hot grant; the pointer moves to the winner only on advance.
module riscv_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    logic [ID_W-1:0] last_q, last_d, idx;
    logic            found;
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_id = grant[i] ? ID_W'(i) : grant_id;
        last_d = advance ? grant_id : last_q;
    end
    always_ff @(posedge clk) begin
        if (rst) last_q <= ID_W'(NUM_REQ - 1);
        else     last_q <= last_d;
    end
endmodule

// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter: shares one riscv_alu among NUM_REQ requesters with a registered response.
module riscv_alu_arbiter
    import riscv_constants::*;
    import riscv_alu_arbiter_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][EXEC_FUN_W-1:0]   req_fun,
    input  logic [NUM_REQ-1:0][WORD_LENGTH-1:0]  req_data1,
    input  logic [NUM_REQ-1:0][WORD_LENGTH-1:0]  req_data2,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [ID_W-1:0]                      resp_id,
    output logic [WORD_LENGTH-1:0]               resp_alu_out,
    output logic                                 resp_br_flag
);
    resp_state_e          state_q, state_d;
    logic [ID_W-1:0]        id_q, id_d, gid;
    logic [WORD_LENGTH-1:0] out_q, out_d, alu_out;
    logic                   br_q, br_d, br_flag;
    logic                   can_accept, hs;
    // Accepting while the consumer drains the register keeps throughput at one op per cycle.
    assign can_accept = !rst && (state_q == EMPTY || resp_ready);
    assign hs         = |(req_valid & req_ready);
    riscv_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .en       (can_accept),
        .advance  (hs),
        .grant    (req_ready),
        .grant_id (gid)
    );
    riscv_alu #(.WORD_LENGTH(WORD_LENGTH)) u_alu (
        .fun     (req_fun[gid]),
        .a       (req_data1[gid]),
        .b       (req_data2[gid]),
        .alu_out (alu_out),
        .br_flag (br_flag)
    );
    always_comb begin
        state_d = hs ? FULL : (resp_ready ? EMPTY : state_q);
        id_d    = hs ? gid : id_q;
        out_d   = hs ? alu_out : out_q;
        br_d    = hs ? br_flag : br_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            id_q    <= '0;
            out_q   <= '0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            out_q   <= out_d;
            br_q    <= br_d;
        end
    end
    assign resp_valid   = state_q == FULL;
    assign resp_id      = id_q;
    assign resp_alu_out = out_q;
    assign resp_br_flag = br_q;
endmodule
